ser_ctl: RTL and testbench
==========================

Name: ser_ctl

Overview:
- Bus-master sequencer for the serial line interface (two-register slave: addr 0 = data, addr 1 = control/status).
- After reset, programs the bitrate once, then polls status continuously.
- Moves bytes between two streaming clients (TX producer, RX consumer) and the serial slave, with round-robin choice when both directions are ready.
- Lets hardware blocks (boot loader, debug monitor) use the UART without the CPU.

Parameters:
- BAUD_CODE, 3'h7: rate code written at init (0=2400 … 2=9600 … 7=115200 at 50 MHz).
- IEN_BITS, 3'b000: interrupt-enable bits written at init (bit0 rcv_rdy, bit1 xmt_rdy, bit2 xmt_empty).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ser_stb  out  1  strobe to serial slave
- ser_we  out  1  write enable
- ser_addr  out  1  0 = data, 1 = control/status
- ser_dout  out  32  write data to slave
- ser_din  in  32  read data from slave
- ser_ack  in  1  slave acknowledge
- tx_data  in  8  byte to transmit
- tx_valid  in  1  TX byte offered
- tx_ready  out  1  TX byte accepted this cycle
- rx_data  out  8  received byte
- rx_valid  out  1  RX byte available
- rx_ready  in  1  consumer takes RX byte
- init_done  out  1  high once the control write has completed
- xmt_empty  out  1  last sampled status bit 2

Behaviour:
- Reset (async, any state): FSM to INIT; ser_stb=0, ser_we=0, ser_addr=0, ser_dout=0, tx_ready=0, rx_valid=0, rx_data=0, init_done=0, xmt_empty=0, rr_last=TX; any held RX byte is discarded.
- Bus rule: each access holds stb/we/addr/dout stable until the cycle with ser_ack=1. Read data is sampled from ser_din in that same ack cycle. The next state is entered on the following edge. With the current slave (ack=stb), every access takes 1 cycle.
- INIT: write addr1, dout = {1'b1, BAUD_CODE, 25'b0, IEN_BITS}. On ack: init_done<=1, go to STAT.
- STAT: read addr1. On ack: latch rcv_rdy=din[0], xmt_rdy=din[1], xmt_empty=din[2]; go to SEL.
- SEL (no bus access, 1 cycle):
  - rx_ok = rcv_rdy & rx slot free.
  - tx_ok = xmt_rdy & tx_valid.
  - Both ok: serve the direction opposite rr_last.
  - Only one ok: serve it.
  - Neither: back to STAT.
- WR: write addr0, dout = {24'b0, tx_data}. tx_ready=1 only in the ack cycle (tx_valid is guaranteed high there); rr_last<=TX; go to STAT.
- RD: read addr0. On ack: rx_data<=din[7:0], rx_valid<=1, rr_last<=RX; go to STAT.
- Status is always re-read after every data access; no stale rdy bits are reused.
- Minimum loop, ack=stb: STAT→SEL→WR = 3 cycles per byte.
- RX holding register (feature off):
  - "Slot free" means rx_valid=0.
  - rx_valid clears on rx_valid & rx_ready.
  - The slave's own buffer provides backpressure; bytes are never dropped here.
- tx_valid dropping before WR: not allowed (client contract). The bench asserts tx_valid stays high until tx_ready.
- A simultaneous rx_ready consume and a new RD load in the same cycle is impossible without the feature, because RD requires the slot to be free in SEL.
- While init_done=0: no TX/RX activity; tx_ready=0.

Optional Feature:
- Macro: SER_CTL_RXBUF_EN.
- With the macro: RX path is a 4-entry FIFO.
  - "Slot free" means count<4.
  - rx_data/rx_valid come from the FIFO head.
  - Simultaneous push (RD ack) and pop (rx_valid & rx_ready) keeps count unchanged; pointers wrap modulo 4.
- Without the macro: single holding register as described above.

Decomposition:
- Package ser_ctl_pkg:
  - FSM state enum {INIT, STAT, SEL, WR, RD}.
  - ADDR_DATA=1'b0, ADDR_CTRL=1'b1.
  - Status bit indices RCV_RDY=0, XMT_RDY=1, XMT_EMPTY=2.
  - Baud code constants.
- Sub-module ser_ctl_rxfifo (4x8, count, push/pop), instantiated only under SER_CTL_RXBUF_EN.

Test Plan:
- Reset release, BAUD_CODE=3'h3 → first bus cycle: stb=1, we=1, addr=1, dout=32'hB000_0000; init_done=1 next cycle; then read of addr1.
- tx_valid=1, tx_data=8'h41, model status=4'b0110 → stb/we/addr0 with dout=32'h41; tx_ready pulses exactly once; status is re-read afterwards.
- Model status rcv_rdy=1, din on data read = 8'h5A, rx_ready=0 → rx_valid=1, rx_data=8'h5A held; no further RD issued while rx_valid=1, even with rcv_rdy=1.
- Both eligible repeatedly (status=4'b0011, tx_valid=1, rx_ready=1) → data accesses alternate RD, WR, RD, WR, … (first RD, since rr_last resets to TX).
- rst asserted mid-WR (stb high) → stb drops asynchronously; next access after release is the INIT control write.
- SER_CTL_RXBUF_EN, rx_ready=0, 5 bytes offered → 4 accepted (8'h01..8'h04); no RD while full; popping one allows the 5th; output order preserved.

Source files
------------

// File: rtl/ser_ctl_pkg.sv
// ser_ctl_pkg: shared types and constants for the serial-line bus-master sequencer.
package ser_ctl_pkg;

    // Sequencer states: program control once, then poll status and move bytes.
    typedef enum logic [2:0] {
        INIT,
        STAT,
        SEL,
        WR,
        RD
    } state_e;

    // Direction served by the most recent data access.
    typedef enum logic {
        DIR_TX = 1'b0,
        DIR_RX = 1'b1
    } dir_e;

    // Serial slave register map.
    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    // Status register bit positions.
    localparam int RCV_RDY   = 0;
    localparam int XMT_RDY   = 1;
    localparam int XMT_EMPTY = 2;

    // Bitrate codes at 50 MHz.
    localparam logic [2:0] BAUD_2400   = 3'h0;
    localparam logic [2:0] BAUD_9600   = 3'h2;
    localparam logic [2:0] BAUD_115200 = 3'h7;

    // Depth of the optional receive FIFO.
    localparam int RX_DEPTH = 4;

    // Control word: bit 31 set, rate code in [30:28], interrupt enables in [2:0].
    function automatic logic [31:0] ctrl_word(input logic [2:0] baud, input logic [2:0] ien);
        return {1'b1, baud, 25'b0, ien};
    endfunction

endpackage

// File: rtl/ser_ctl_rxfifo.sv
// ser_ctl_rxfifo: 4 x 8-bit receive FIFO used by ser_ctl when SER_CTL_RXBUF_EN is defined.
module ser_ctl_rxfifo
    import ser_ctl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       full_o
);

    localparam int PW = $clog2(RX_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_ONE = {{PW{1'b0}}, 1'b1};

    logic [7:0]    mem_q [RX_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == RX_DEPTH[PW:0]);
    assign valid_o = (count_q != '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && valid_o;
    // Empty FIFO presents zero so the output matches the reset value.
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : 8'h00;

    // Storage write on push.
    // NOTE: data storage has no reset; only pointers and count need a defined value,
    // and non-blocking assignments keep every flop update order-independent.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally modulo the depth; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ser_ctl.sv
// ser_ctl: bus master that programs the serial slave once, then polls status and
// moves bytes between a TX producer, an RX consumer and the slave data register.
// Define SER_CTL_RXBUF_EN to replace the single RX holding register with a 4-entry FIFO.
module ser_ctl
    import ser_ctl_pkg::*;
#(
    parameter logic [2:0] BAUD_CODE = BAUD_115200,
    parameter logic [2:0] IEN_BITS  = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ser_stb,
    output logic        ser_we,
    output logic        ser_addr,
    output logic [31:0] ser_dout,
    input  logic [31:0] ser_din,
    input  logic        ser_ack,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        init_done,
    output logic        xmt_empty
);

    localparam logic [31:0] CTRL_WORD = ctrl_word(BAUD_CODE, IEN_BITS);

    state_e state_q;
    state_e state_d;
    logic   bus_en_q;      // low for the first cycle after reset so the bus is idle in reset
    logic   init_done_q;
    logic   rcv_rdy_q;
    logic   xmt_rdy_q;
    logic   xmt_empty_q;
    dir_e   rr_last_q;

    logic   bus_ack;
    logic   rx_ok;
    logic   tx_ok;
    logic   rx_push;
    logic   rx_pop;
    logic   rx_slot_free;
    logic   unused_din_hi;

    assign bus_ack       = ser_stb && ser_ack;
    assign rx_ok         = rcv_rdy_q && rx_slot_free;
    assign tx_ok         = xmt_rdy_q && tx_valid;
    assign rx_push       = (state_q == RD) && bus_ack;
    assign rx_pop        = rx_valid && rx_ready;
    assign init_done     = init_done_q;
    assign xmt_empty     = xmt_empty_q;
    assign unused_din_hi = ^ser_din[31:8];

    // State register and bus enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= INIT;
            bus_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bus_en_q <= 1'b1;
        end
    end

    // Next-state: each access advances only on its ack; SEL arbitrates for one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:   if (bus_ack) state_d = STAT;
            STAT:   if (bus_ack) state_d = SEL;
            SEL: begin
                if (rx_ok && (!tx_ok || rr_last_q == DIR_TX)) begin
                    state_d = RD;
                end else if (tx_ok) begin
                    state_d = WR;
                end else begin
                    state_d = STAT;
                end
            end
            WR:     if (bus_ack) state_d = STAT;
            RD:     if (bus_ack) state_d = STAT;
            default: state_d = INIT;
        endcase
    end

    // Bus outputs held stable for the whole access; TX handshake only in the WR ack cycle.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        ser_stb  = 1'b0;
        ser_we   = 1'b0;
        ser_addr = ADDR_DATA;
        ser_dout = 32'h0;
        tx_ready = 1'b0;
        if (bus_en_q) begin
            case (state_q)
                INIT: begin
                    ser_stb  = 1'b1;
                    ser_we   = 1'b1;
                    ser_addr = ADDR_CTRL;
                    ser_dout = CTRL_WORD;
                end
                STAT: begin
                    ser_stb  = 1'b1;
                    ser_addr = ADDR_CTRL;
                end
                WR: begin
                    ser_stb  = 1'b1;
                    ser_we   = 1'b1;
                    ser_dout = {24'h0, tx_data};
                    tx_ready = ser_ack;
                end
                RD: begin
                    ser_stb  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Init flag, latched status bits and round-robin history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_done_q <= 1'b0;
            rcv_rdy_q   <= 1'b0;
            xmt_rdy_q   <= 1'b0;
            xmt_empty_q <= 1'b0;
            rr_last_q   <= DIR_TX;
        end else begin
            if (state_q == INIT && bus_ack) begin
                init_done_q <= 1'b1;
            end
            if (state_q == STAT && bus_ack) begin
                rcv_rdy_q   <= ser_din[RCV_RDY];
                xmt_rdy_q   <= ser_din[XMT_RDY];
                xmt_empty_q <= ser_din[XMT_EMPTY];
            end
            if (state_q == WR && bus_ack) begin
                rr_last_q <= DIR_TX;
            end
            if (rx_push) begin
                rr_last_q <= DIR_RX;
            end
        end
    end

`ifdef SER_CTL_RXBUF_EN
    logic rx_full;

    ser_ctl_rxfifo u_rxfifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .data_i  (ser_din[7:0]),
        .pop_i   (rx_pop),
        .data_o  (rx_data),
        .valid_o (rx_valid),
        .full_o  (rx_full)
    );

    assign rx_slot_free = !rx_full;
`else
    logic       rx_valid_q;
    logic [7:0] rx_data_q;

    // Single RX holding register; a load only happens when it is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
        end else if (rx_push) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= ser_din[7:0];
        end else if (rx_pop) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign rx_valid     = rx_valid_q;
    assign rx_data      = rx_data_q;
    assign rx_slot_free = !rx_valid_q;
`endif

endmodule

// File: tb/tb_ser_ctl.sv
// tb_ser_ctl: randomized bench for ser_ctl with a transaction-level reference model
// and scoreboard queues for bus accesses, TX bytes and RX bytes.
`timescale 1ns/1ps
module tb_ser_ctl;

    localparam logic [31:0] CTRL_EXP = 32'hB000_0000;  // rate code 3, no interrupts
`ifdef SER_CTL_RXBUF_EN
    localparam int RX_CAP = 4;
`else
    localparam int RX_CAP = 1;
`endif

    typedef struct packed {
        logic        we;
        logic        addr;
        logic [31:0] dout;
    } bus_txn_t;

    localparam bus_txn_t TXN_CTRL = '{we: 1'b1, addr: 1'b1, dout: CTRL_EXP};
    localparam bus_txn_t TXN_STAT = '{we: 1'b0, addr: 1'b1, dout: 32'h0};
    localparam bus_txn_t TXN_RD   = '{we: 1'b0, addr: 1'b0, dout: 32'h0};

    logic        clk;
    logic        rst;
    logic        ser_stb;
    logic        ser_we;
    logic        ser_addr;
    logic [31:0] ser_dout;
    logic [31:0] ser_din;
    logic        ser_ack;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        init_done;
    logic        xmt_empty;

    // Slave model: ack in the same cycle as strobe.
    logic [2:0]  status_bits;
    logic [7:0]  slave_rd_byte;
    assign ser_ack = ser_stb;
    assign ser_din = ser_addr ? {29'h0, status_bits} : {24'h0, slave_rd_byte};

    ser_ctl #(
        .BAUD_CODE (3'h3),
        .IEN_BITS  (3'b000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_stb   (ser_stb),
        .ser_we    (ser_we),
        .ser_addr  (ser_addr),
        .ser_dout  (ser_dout),
        .ser_din   (ser_din),
        .ser_ack   (ser_ack),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .init_done (init_done),
        .xmt_empty (xmt_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Scoreboard queues.
    bus_txn_t   exp_bus[$];
    logic [7:0] exp_rx[$];
    logic [7:0] tx_exp[$];

    // Stimulus knobs.
    int         tx_pct = 0;
    int         rx_pct = 0;
    bit         st_rand = 1'b0;
    logic [2:0] st_fixed = 3'b000;
    bit         tx_fixed_en = 1'b0;
    logic [7:0] tx_fixed = 8'h00;
    int         rd_mode = 0;        // 0 random, 1 fixed, 2 counting from 1
    logic [7:0] rd_fixed = 8'h00;
    int         rd_base = 0;

    // Model state.
    logic [2:0] st_seen = 3'b000;
    bit         sel_cycle = 1'b0;
    bit         m_init = 1'b0;
    bit         live = 1'b0;
    bit         last_tx = 1'b1;
    bit         start_pending = 1'b1;
    bit         tx_hs = 1'b0;
    int         idle = 0;
    int         rd_acks = 0;
    int         wr_acks = 0;

    // Driver: inputs change 1 ns after the rising edge.
    initial begin
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        rx_ready      = 1'b0;
        status_bits   = 3'b000;
        slave_rd_byte = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                tx_valid = 1'b0;
                rx_ready = 1'b0;
            end else begin
                if (tx_valid && tx_hs) tx_valid = 1'b0;
                if (!tx_valid && ($urandom_range(99) < tx_pct)) begin
                    tx_data  = tx_fixed_en ? tx_fixed : 8'($urandom);
                    tx_valid = 1'b1;
                    tx_exp.push_back(tx_data);
                end
                rx_ready    = ($urandom_range(99) < rx_pct);
                status_bits = st_rand ? 3'($urandom) : st_fixed;
                case (rd_mode)
                    1:       slave_rd_byte = rd_fixed;
                    2:       slave_rd_byte = 8'(rd_acks - rd_base + 1);
                    default: slave_rd_byte = 8'($urandom);
                endcase
            end
        end
    end

    // Reference model and monitor, sampled on the falling edge.
    always @(negedge clk) begin : model
        bus_txn_t e;
        bit       got_ack;
        bit       exp_txr;
        bit       push_ev;
        bit       rx_ok;
        bit       tx_ok;
        got_ack = ser_stb && ser_ack;
        exp_txr = 1'b0;
        push_ev = 1'b0;
        if (rst) begin
            check("rst_stb", 64'(ser_stb), 64'(0));
            check("rst_we", 64'(ser_we), 64'(0));
            check("rst_addr", 64'(ser_addr), 64'(0));
            check("rst_dout", 64'(ser_dout), 64'(0));
            check("rst_tx_ready", 64'(tx_ready), 64'(0));
            check("rst_rx_valid", 64'(rx_valid), 64'(0));
            check("rst_rx_data", 64'(rx_data), 64'(0));
            check("rst_init_done", 64'(init_done), 64'(0));
            check("rst_xmt_empty", 64'(xmt_empty), 64'(0));
            exp_bus.delete();
            exp_rx.delete();
            tx_exp.delete();
            sel_cycle     = 1'b0;
            m_init        = 1'b0;
            live          = 1'b0;
            last_tx       = 1'b1;
            start_pending = 1'b1;
            tx_hs         = 1'b0;
            idle          = 0;
        end else begin
            if (start_pending) begin
                exp_bus.push_back(TXN_CTRL);
                exp_bus.push_back(TXN_STAT);
                start_pending = 1'b0;
            end
            check("init_done", 64'(init_done), 64'(m_init));

            // Arbitration cycle right after a status read: no bus access.
            if (sel_cycle) begin
                check("sel_no_access", 64'(ser_stb), 64'(0));
                check("xmt_empty", 64'(xmt_empty), 64'(st_seen[2]));
                rx_ok = st_seen[0] && (exp_rx.size() < RX_CAP);
                tx_ok = st_seen[1] && tx_valid;
                if (rx_ok && (!tx_ok || last_tx)) begin
                    exp_bus.push_back(TXN_RD);
                    last_tx = 1'b0;
                end else if (tx_ok) begin
                    check("tx_offer_tracked", 64'(tx_exp.size() != 0), 64'(1));
                    if (tx_exp.size() != 0) begin
                        exp_bus.push_back('{we: 1'b1, addr: 1'b0, dout: {24'h0, tx_exp[0]}});
                    end
                    last_tx = 1'b1;
                end
                exp_bus.push_back(TXN_STAT);
                sel_cycle = 1'b0;
            end else if (live) begin
                check("bus_busy", 64'(ser_stb), 64'(1));
            end

            if (got_ack) begin
                idle = 0;
                live = 1'b1;
                if (exp_bus.size() == 0) begin
                    fail("bus_unexpected_access");
                end else begin
                    e = exp_bus.pop_front();
                    check("bus_we", 64'(ser_we), 64'(e.we));
                    check("bus_addr", 64'(ser_addr), 64'(e.addr));
                    if (e.we) check("bus_dout", 64'(ser_dout), 64'(e.dout));
                    if (e == TXN_CTRL) begin
                        m_init = 1'b1;
                    end else if (!e.we && e.addr) begin
                        st_seen   = status_bits;
                        sel_cycle = 1'b1;
                    end else if (!e.we) begin
                        push_ev = 1'b1;
                        rd_acks++;
                    end else begin
                        exp_txr = 1'b1;
                        wr_acks++;
                        if (tx_exp.size() != 0) void'(tx_exp.pop_front());
                    end
                end
            end else begin
                idle++;
                if (idle > 6) begin
                    fail("bus_stalled");
                    idle = 0;
                end
            end

            check("tx_ready", 64'(tx_ready), 64'(exp_txr));
            tx_hs = tx_ready;

            check("rx_valid", 64'(rx_valid), 64'(exp_rx.size() != 0));
            if (exp_rx.size() != 0) begin
                check("rx_data", 64'(rx_data), 64'(exp_rx[0]));
                if (rx_ready) void'(exp_rx.pop_front());
            end
            if (push_ev) exp_rx.push_back(slave_rd_byte);
        end
    end

    task automatic wait_init();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = init_done;
        end
        check("init_reached", 64'(ok), 64'(1));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Directed phases followed by random traffic.
    initial begin
        bit got;
        int rd0;
        int wr0;
        int rd_d;
        int wr_d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        release_reset();
        wait_init();

        // One TX byte, status xmt_empty|xmt_rdy.
        st_fixed    = 3'b110;
        tx_fixed_en = 1'b1;
        tx_fixed    = 8'h41;
        tx_pct      = 100;
        got         = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = tx_ready;
        end
        tx_pct      = 0;
        tx_fixed_en = 1'b0;
        check("tx41_accepted", 64'(got), 64'(1));
        repeat (12) @(negedge clk);

        // RX byte held while the consumer stalls.
        st_fixed = 3'b001;
        rd_mode  = 1;
        rd_fixed = 8'h5A;
        rx_pct   = 0;
        rd0      = rd_acks;
        repeat (40) @(negedge clk);
        check("rx_hold_rd_count", 64'(rd_acks - rd0), 64'(RX_CAP));
        check("rx_hold_valid", 64'(rx_valid), 64'(1));
        check("rx_hold_data", 64'(rx_data), 64'(8'h5A));
        rx_pct = 100;
        st_fixed = 3'b000;
        repeat (20) @(negedge clk);

        // Both directions eligible every poll: accesses alternate.
        st_fixed = 3'b011;
        rd_mode  = 0;
        tx_pct   = 100;
        rx_pct   = 100;
        rd0      = rd_acks;
        wr0      = wr_acks;
        repeat (60) @(negedge clk);
        rd_d = rd_acks - rd0;
        wr_d = wr_acks - wr0;
        check("alt_balance", 64'((rd_d - wr_d <= 1) && (wr_d - rd_d <= 1) && rd_d > 5), 64'(1));
        tx_pct   = 0;
        st_fixed = 3'b000;
        repeat (10) @(negedge clk);

        // Fill the RX path with counting bytes, then free one slot.
        st_fixed = 3'b001;
        rd_mode  = 2;
        rd_base  = rd_acks;
        rx_pct   = 0;
        repeat (40) @(negedge clk);
        check("rx_full_rd_count", 64'(rd_acks - rd_base), 64'(RX_CAP));
        rx_pct = 100;
        @(negedge clk);
        rx_pct = 0;
        repeat (20) @(negedge clk);
        check("rx_after_pop_rd_count", 64'(rd_acks - rd_base), 64'(RX_CAP + 1));
        rx_pct   = 100;
        st_fixed = 3'b000;
        rd_mode  = 0;
        repeat (20) @(negedge clk);

        // Random traffic.
        st_rand = 1'b1;
        tx_pct  = 50;
        rx_pct  = 60;
        repeat (3000) @(negedge clk);

        // Reset in the middle of a data write.
        st_rand  = 1'b0;
        st_fixed = 3'b010;
        tx_pct   = 100;
        got      = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = ser_stb && ser_we && (ser_addr == 1'b0);
        end
        if (got) begin
            #1 rst = 1'b1;
            #1 check("async_stb_drop", 64'(ser_stb), 64'(0));
            repeat (3) @(negedge clk);
            release_reset();
            wait_init();
        end else begin
            fail("mid_wr_not_found");
        end

        st_rand = 1'b1;
        tx_pct  = 40;
        rx_pct  = 50;
        repeat (500) @(negedge clk);

        st_rand  = 1'b0;
        st_fixed = 3'b000;
        tx_pct   = 0;
        rx_pct   = 100;
        repeat (30) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

endmodule
